ex_alu: RTL and testbench



---
 rtl/ex_alu.sv | 116 +++++++++++
 tb/tb_ex_alu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ex_alu.sv
// Execute-stage ALU for the RV32I pipeline: result, branch decision and
// control-transfer target, with EX/MEM capture registers.
module ex_alu (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic [31:0] i_Imm_SignExt,
  input  logic [31:0] i_NPC,
  input  logic [2:0]  i_ALUop,
  input  logic [2:0]  i_func3,
  input  logic        i_func7,
  output logic [31:0] o_ALUOutput,
  output logic        o_branch,
  output logic [31:0] o_target,
  output logic [31:0] o_mem_ALUOutput,
  output logic        o_mem_branch,
  output logic [31:0] o_mem_target,
  output logic [31:0] o_mem_B,
  output logic [2:0]  o_mem_func3
);

  localparam logic [2:0] CLS_MEM   = 3'b000;
  localparam logic [2:0] CLS_BR    = 3'b001;
  localparam logic [2:0] CLS_OPIMM = 3'b010;
  localparam logic [2:0] CLS_OP    = 3'b011;
  localparam logic [2:0] CLS_LUI   = 3'b100;
  localparam logic [2:0] CLS_AUIPC = 3'b101;
  localparam logic [2:0] CLS_JAL   = 3'b110;
  localparam logic [2:0] CLS_JALR  = 3'b111;

  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] a_plus_imm;
  logic [31:0] npc_plus_imm;
  logic [31:0] npc_plus_4;
  logic        lt_s;
  logic        lt_u;
  logic        eq_ab;

  // OP uses rs2 as the second operand; OP-IMM uses the immediate.
  assign op2          = (i_ALUop == CLS_OP) ? i_B : i_Imm_SignExt;
  assign shamt        = op2[4:0];
  assign a_plus_imm   = i_A + i_Imm_SignExt;
  assign npc_plus_imm = i_NPC + i_Imm_SignExt;
  assign npc_plus_4   = i_NPC + 32'd4;

  // Comparisons against op2 serve SLT/SLTU; branches always compare rs1 with rs2
  // which is op2 only for OP, so branch compares use i_B directly below.
  assign lt_s  = $signed(i_A) < $signed(op2);
  assign lt_u  = i_A < op2;
  assign eq_ab = (i_A == i_B);

  // Result, taken flag and target for the instruction currently in EX.
  always_comb begin
    o_ALUOutput = 32'd0;
    o_branch    = 1'b0;
    o_target    = npc_plus_imm;
    case (i_ALUop)
      CLS_MEM: o_ALUOutput = a_plus_imm;
      CLS_BR: begin
        case (i_func3)
          3'b000:  o_branch = eq_ab;
          3'b001:  o_branch = !eq_ab;
          3'b100:  o_branch = $signed(i_A) <  $signed(i_B);
          3'b101:  o_branch = $signed(i_A) >= $signed(i_B);
          3'b110:  o_branch = i_A <  i_B;
          3'b111:  o_branch = i_A >= i_B;
          default: o_branch = 1'b0;
        endcase
      end
      CLS_OPIMM, CLS_OP: begin
        case (i_func3)
          // SUB exists only in the register form; ADDI ignores bit 30.
          3'b000:  o_ALUOutput = (i_ALUop == CLS_OP && i_func7) ? i_A - op2 : i_A + op2;
          3'b001:  o_ALUOutput = i_A << shamt;
          3'b010:  o_ALUOutput = {31'd0, lt_s};
          3'b011:  o_ALUOutput = {31'd0, lt_u};
          3'b100:  o_ALUOutput = i_A ^ op2;
          3'b101:  o_ALUOutput = i_func7 ? 32'($signed(i_A) >>> shamt) : i_A >> shamt;
          3'b110:  o_ALUOutput = i_A | op2;
          default: o_ALUOutput = i_A & op2;
        endcase
      end
      CLS_LUI:   o_ALUOutput = i_Imm_SignExt;
      CLS_AUIPC: o_ALUOutput = npc_plus_imm;
      CLS_JAL: begin
        o_ALUOutput = npc_plus_4;
        o_branch    = 1'b1;
      end
      default: begin
        o_ALUOutput = npc_plus_4;
        o_branch    = 1'b1;
        o_target    = {a_plus_imm[31:1], 1'b0};
      end
    endcase
  end

  // EX/MEM pipeline register: loads every cycle, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_mem_ALUOutput <= 32'd0;
      o_mem_branch    <= 1'b0;
      o_mem_target    <= 32'd0;
      o_mem_B         <= 32'd0;
      o_mem_func3     <= 3'd0;
    end else begin
      o_mem_ALUOutput <= o_ALUOutput;
      o_mem_branch    <= o_branch;
      o_mem_target    <= o_target;
      o_mem_B         <= i_B;
      o_mem_func3     <= i_func3;
    end
  end

endmodule

// File: tb/tb_ex_alu.sv
// Bench for ex_alu: directed test-plan cases plus random stimulus against a
// behavioural reference.
module tb_ex_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a, b, imm, npc;
  logic [2:0]  alu_op, f3;
  logic        f7;
  logic [31:0] alu_out, target, mem_alu, mem_target, mem_b;
  logic        branch, mem_branch;
  logic [2:0]  mem_f3;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res, exp_tgt;
  logic        exp_br;

  ex_alu dut (
    .i_clk(clk), .i_reset(rst_n), .i_A(a), .i_B(b), .i_Imm_SignExt(imm),
    .i_NPC(npc), .i_ALUop(alu_op), .i_func3(f3), .i_func7(f7),
    .o_ALUOutput(alu_out), .o_branch(branch), .o_target(target),
    .o_mem_ALUOutput(mem_alu), .o_mem_branch(mem_branch),
    .o_mem_target(mem_target), .o_mem_B(mem_b), .o_mem_func3(mem_f3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model written from the instruction semantics with integer math.
  function automatic void model(input logic [31:0] ra, rb, ri, pc,
                                input logic [2:0] cls, fn3, input logic fn7,
                                output logic [31:0] res, output logic br,
                                output logic [31:0] tgt);
    longint sa, sb, so, ua, ub, uo;
    logic [31:0] o2;
    int sh;
    sa = longint'($signed(ra)); sb = longint'($signed(rb));
    ua = longint'({32'd0, ra});  ub = longint'({32'd0, rb});
    res = 0; br = 0; tgt = 32'(longint'({32'd0, pc}) + longint'({32'd0, ri}));
    if (cls == 3'd0) res = 32'(ua + longint'({32'd0, ri}));
    else if (cls == 3'd1) begin
      if      (fn3 == 0) br = (ua == ub);
      else if (fn3 == 1) br = (ua != ub);
      else if (fn3 == 4) br = (sa <  sb);
      else if (fn3 == 5) br = (sa >= sb);
      else if (fn3 == 6) br = (ua <  ub);
      else if (fn3 == 7) br = (ua >= ub);
    end else if (cls == 3'd2 || cls == 3'd3) begin
      o2 = (cls == 3'd3) ? rb : ri;
      so = longint'($signed(o2)); uo = longint'({32'd0, o2});
      sh = int'(uo % 32);
      case (fn3)
        0: res = (cls == 3'd3 && fn7) ? 32'(ua - uo) : 32'(ua + uo);
        1: res = 32'(ua * (64'd1 << sh));
        2: res = (sa < so) ? 1 : 0;
        3: res = (ua < uo) ? 1 : 0;
        4: res = ra ^ o2;
        5: res = fn7 ? 32'(sa / (64'sd1 <<< sh) - ((sa < 0 && (sa % (64'sd1 <<< sh)) != 0) ? 1 : 0))
                     : 32'(ua / (64'd1 << sh));
        6: res = ra | o2;
        default: res = ra & o2;
      endcase
    end else if (cls == 3'd4) res = ri;
    else if (cls == 3'd5) res = tgt;
    else begin
      res = 32'(longint'({32'd0, pc}) + 4);
      br = 1;
      if (cls == 3'd7) tgt = 32'(ua + longint'({32'd0, ri})) & 32'hFFFF_FFFE;
    end
  endfunction

  task automatic drive(input logic [31:0] ta, tb_, ti, tp, input logic [2:0] tc, tf3, input logic tf7);
    a = ta; b = tb_; imm = ti; npc = tp; alu_op = tc; f3 = tf3; f7 = tf7;
    model(ta, tb_, ti, tp, tc, tf3, tf7, exp_res, exp_br, exp_tgt);
  endtask

  // Drive on the falling edge, check combinational, then registered after the edge.
  task automatic step(input string tag, input logic [31:0] ta, tb_, ti, tp,
                      input logic [2:0] tc, tf3, input logic tf7);
    logic [31:0] r, t, bb; logic br; logic [2:0] ff;
    @(negedge clk);
    drive(ta, tb_, ti, tp, tc, tf3, tf7);
    #1;
    check({tag, ".res"}, alu_out, exp_res);
    check({tag, ".br"}, 32'(branch), 32'(exp_br));
    if (tc == 3'd1 || tc >= 3'd6) check({tag, ".tgt"}, target, exp_tgt);
    r = exp_res; br = exp_br; t = exp_tgt; bb = tb_; ff = tf3;
    @(posedge clk); #1;
    check({tag, ".mres"}, mem_alu, r);
    check({tag, ".mbr"}, 32'(mem_branch), 32'(br));
    check({tag, ".mtgt"}, mem_target, t);
    check({tag, ".mB"}, mem_b, bb);
    check({tag, ".mf3"}, 32'(mem_f3), 32'(ff));
  endtask

  initial begin
    drive(32'h1111_0000, 32'h0000_00AA, 32'h10, 32'h400, 3'd0, 3'd2, 1'b0);
    #12;
    check("rst.mres", mem_alu, 0);
    check("rst.mbr", 32'(mem_branch), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first.mres", mem_alu, 32'h1111_0010);
    check("first.mB", mem_b, 32'hAA);
    // Asynchronous reset mid-cycle with nonzero inputs.
    #2 rst_n = 1'b0;
    #1;
    check("arst.mres", mem_alu, 0);
    check("arst.mbr", 32'(mem_branch), 0);
    check("arst.mB", mem_b, 0);
    @(posedge clk); #1;
    check("arst_hold.mres", mem_alu, 0);
    #2 rst_n = 1'b1;
    #1;
    check("rel_nocap.mres", mem_alu, 0);
    @(posedge clk); #1;
    check("rel_cap.mres", mem_alu, 32'h1111_0010);

    // Directed test-plan cases with hand-derived constants.
    step("add_ovf", 32'h7FFF_FFFF, 1, 0, 0, 3'd3, 3'd0, 1'b0);
    check("add_ovf.k", mem_alu, 32'h8000_0000);
    step("sub", 32'h7FFF_FFFF, 1, 0, 0, 3'd3, 3'd0, 1'b1);
    check("sub.k", mem_alu, 32'h7FFF_FFFE);
    step("sub_neg", 5, 7, 0, 0, 3'd3, 3'd0, 1'b1);
    check("sub_neg.k", mem_alu, 32'hFFFF_FFFE);
    step("sra", 32'h8000_0000, 32'h24, 0, 0, 3'd3, 3'd5, 1'b1);
    check("sra.k", mem_alu, 32'hF800_0000);
    step("slt", 32'hFFFF_FFFF, 1, 0, 0, 3'd3, 3'd2, 1'b0);
    check("slt.k", mem_alu, 1);
    step("sltu", 32'hFFFF_FFFF, 1, 0, 0, 3'd3, 3'd3, 1'b0);
    check("sltu.k", mem_alu, 0);
    step("blt", 32'hFFFF_FFFE, 3, 32'hFFFF_FFF0, 32'h100, 3'd1, 3'd4, 1'b0);
    check("blt.k_br", 32'(mem_branch), 1);
    check("blt.k_tgt", mem_target, 32'hF0);
    check("blt.k_res", mem_alu, 0);
    step("bgeu", 32'hFFFF_FFFE, 3, 32'hFFFF_FFF0, 32'h100, 3'd1, 3'd7, 1'b0);
    check("bgeu.k_br", 32'(mem_branch), 1);
    step("beq", 3, 4, 32'hFFFF_FFF0, 32'h100, 3'd1, 3'd0, 1'b0);
    check("beq.k_br", 32'(mem_branch), 0);
    step("jal", 0, 0, 8, 32'h200, 3'd6, 3'd0, 1'b0);
    check("jal.k_res", mem_alu, 32'h204);
    check("jal.k_tgt", mem_target, 32'h208);
    check("jal.k_br", 32'(mem_branch), 1);
    step("jalr", 32'h1001, 0, 2, 32'h200, 3'd7, 3'd0, 1'b0);
    check("jalr.k_tgt", mem_target, 32'h1002);
    step("addi_nof7", 10, 0, 3, 0, 3'd2, 3'd0, 1'b1);
    check("addi_nof7.k", mem_alu, 13);
    step("nop", 0, 0, 0, 32'h300, 3'd2, 3'd0, 1'b0);
    check("nop.k", mem_alu, 0);

    // Back-to-back ADDI then LUI: each result appears one cycle later.
    step("pipe_addi", 32'h20, 32'h55, 32'h7, 32'h400, 3'd2, 3'd0, 1'b0);
    check("pipe_addi.k", mem_alu, 32'h27);
    step("pipe_lui", 0, 32'h66, 32'h1234_5000, 32'h404, 3'd4, 3'd2, 1'b0);
    check("pipe_lui.k", mem_alu, 32'h1234_5000);
    check("pipe_lui.kB", mem_b, 32'h66);
    check("pipe_lui.kf3", 32'(mem_f3), 2);

    // Random stimulus; operands are sometimes forced equal or to edge values.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      step("rand", ra, rb, $urandom, $urandom, 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
